ram_load_ctrl: RTL
==================

Name: ram_load_ctrl

Overview:
- Host-side RAM loader and bus arbiter for the 16-bit microprogrammed computer.
- Takes a burst request (base address, word count), then freezes the microcode sequencer at a safe point.
- Writes each word by injecting its own destination-select code, write enable and bus value in place of the microcode fields: one LDRAMD cycle, then one LDRAM write cycle per word.
- Releases the bus when the burst finishes. Lets a host or debug port preload programs without touching the microcode ROM.

Parameters:
- DATA_WIDTH, 16, width of the data bus, address and data words.
- CNT_WIDTH, 8, width of the burst word count.
- A_LDRAM, 9, destination-select code for RAM read/write.
- A_LDRAMD, 10, destination-select code for RAM address load.

Ports:
- clk  input  1  system clock; the execute-phase clock of the datapath.
- clr  input  1  synchronous active-high reset.
- start  input  1  burst request; sampled only in IDLE.
- base_addr  input  DATA_WIDTH  first RAM address of the burst.
- word_count  input  CNT_WIDTH  number of words to write.
- wr_data  input  DATA_WIDTH  host data word.
- wr_valid  input  1  wr_data is valid.
- wr_ready  output  1  controller accepts wr_data this cycle.
- abort  input  1  terminate the burst early.
- core_hold  output  1  stall request to the microcode sequencer.
- core_idle  input  1  sequencer is stalled at an instruction boundary.
- ovr_en  output  1  override active; datapath muxes use ovr_* instead of microcode A/WE and the bus mux result.
- ovr_A  output  5  injected destination-select code; 0 (no-op) when not overriding.
- ovr_WE  output  1  injected RAM write enable.
- ovr_data  output  DATA_WIDTH  value driven onto the data bus.
- busy  output  1  not in IDLE.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  valid with done; burst was aborted.
- words_written  output  CNT_WIDTH  words committed in the current/last burst.

Behaviour:
- Interface: one clock (`clk`); reset `clr` is synchronous and active-high.
- All outputs are registered except wr_ready, which is decoded from state.
- Reset: state IDLE. All outputs 0, including words_written. Internal address, count and data registers are cleared to 0.
- clr mid-burst: return to IDLE next edge. Drop core_hold and ovr_en in the same edge. No done pulse.
- States: IDLE, REQ, ADDR, LOAD, WRITE, FIN.
- IDLE:
  - start=1 with word_count!=0: latch base_addr and word_count, clear words_written, go to REQ.
  - start=1 with word_count=0: pulse done (err=0) next cycle and stay IDLE; core_hold is never raised.
  - start in any other state is ignored.
- REQ: core_hold=1. Wait for core_idle=1 with no timeout, then go to ADDR.
- ADDR (exactly 1 cycle): ovr_en=1, ovr_A=A_LDRAMD, ovr_WE=0, ovr_data=addr. Next state LOAD.
- LOAD:
  - ovr_en=1, ovr_A=0, ovr_WE=0; wr_ready=1.
  - On wr_valid&wr_ready, capture wr_data and go to WRITE.
  - Waits indefinitely for wr_valid.
- WRITE (exactly 1 cycle):
  - ovr_en=1, ovr_A=A_LDRAM, ovr_WE=1, ovr_data=captured data.
  - Increment addr modulo 2^DATA_WIDTH (0xFFFF wraps to 0x0000).
  - Decrement count; increment words_written.
  - If the remaining count was 1, go to FIN; otherwise go to ADDR.
- FIN (1 cycle): done=1; ovr_en=0, ovr_A=0; core_hold=0. Next state IDLE.
- core_hold stays 1 from entering REQ until FIN; core_idle is not rechecked after REQ.
- abort:
  - Honoured in REQ, ADDR and LOAD: go to FIN with err=1.
  - In WRITE, the current write completes and abort is latched; FIN follows with err=1 unless that was the last word, which gives err=0.
  - abort and wr_valid in the same LOAD cycle: abort wins, no handshake, wr_ready is forced to 0.
- Minimum throughput: 3 cycles per word (ADDR, LOAD with wr_valid already high, WRITE).
- err is 0 whenever done=0.

Test Plan:
- Reset: assert clr mid-LOAD of a 4-word burst → next cycle state IDLE, core_hold=0, ovr_en=0, words_written=0, no done pulse.
- Single word: start with base 0x0020, count 1, wr_data 0xBEEF held valid, core_idle raised 2 cycles after core_hold → ADDR drives ovr_A=10/ovr_data=0x0020, WRITE drives ovr_A=9/WE=1/0xBEEF, done=1 err=0, words_written=1.
- Burst with wrap: base 0xFFFE, count 3, data 0x1111/0x2222/0x3333 with a 2-cycle valid gap before the second → address phases 0xFFFE, 0xFFFF, 0x0000; three WE pulses; total cycles after core_idle = 9 + 2.
- Zero count: start with count 0 → done=1 err=0 next cycle, core_hold never asserted.
- Abort: count 5, abort asserted in LOAD of word 3 alongside wr_valid → no third write, done=1 err=1, words_written=2, core_hold released in FIN.
- Ignored start: pulse start with new parameters while busy → original burst unaffected, final addresses match the first base.

Source files
------------

// File: rtl/ram_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_load_ctrl
// Description : Host-side RAM loader and bus arbiter for the 16-bit
//               microprogrammed computer. Accepts a burst request (base
//               address, word count), stalls the microcode sequencer at an
//               instruction boundary, then overrides the destination-select,
//               write-enable and bus fields to write each host word into RAM
//               (one LDRAMD address cycle, one LDRAM write cycle per word).
// Ports       :
//   clk            execute-phase clock of the datapath
//   clr            synchronous active-high reset
//   start          burst request, sampled only when idle
//   base_addr      first RAM address of the burst
//   word_count     number of words to write (0 = immediate done)
//   wr_data        host data word
//   wr_valid       wr_data is valid
//   wr_ready       controller accepts wr_data this cycle (decoded from state)
//   abort          terminate the burst early
//   core_hold      stall request to the microcode sequencer
//   core_idle      sequencer is stalled at an instruction boundary
//   ovr_en         datapath muxes select ovr_* instead of microcode fields
//   ovr_A          injected destination-select code (0 = no-op)
//   ovr_WE         injected RAM write enable
//   ovr_data       value driven onto the data bus
//   busy           controller is not idle
//   done           one-cycle pulse at burst end
//   err            valid with done; burst was aborted
//   words_written  words committed in the current/last burst
// Revision    : 1.0 - initial release
// ============================================================================
module ram_load_ctrl #(
  parameter int         DATA_WIDTH = 16,
  parameter int         CNT_WIDTH  = 8,
  parameter logic [4:0] A_LDRAM    = 5'd9,
  parameter logic [4:0] A_LDRAMD   = 5'd10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  abort,
  output logic                  core_hold,
  input  logic                  core_idle,
  output logic                  ovr_en,
  output logic [4:0]            ovr_A,
  output logic                  ovr_WE,
  output logic [DATA_WIDTH-1:0] ovr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  words_written
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_ADDR  = 3'd2;
  localparam logic [2:0] c_LOAD  = 3'd3;
  localparam logic [2:0] c_WRITE = 3'd4;
  localparam logic [2:0] c_FIN   = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;

  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic [CNT_WIDTH-1:0]  r_words;
  logic [CNT_WIDTH-1:0]  w_words_nxt;

  logic                  w_hs;
  logic                  w_start_burst;
  logic                  w_zero_start;
  logic                  w_last;
  logic                  w_err_nxt;

  // Next values of the registered outputs
  logic                  w_hold_nxt;
  logic                  w_ovr_en_nxt;
  logic [4:0]            w_ovr_a_nxt;
  logic                  w_ovr_we_nxt;
  logic [DATA_WIDTH-1:0] w_ovr_data_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_err_out_nxt;

  logic                  r_core_hold;
  logic                  r_ovr_en;
  logic [4:0]            r_ovr_a;
  logic                  r_ovr_we;
  logic [DATA_WIDTH-1:0] r_ovr_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  // Abort beats a simultaneous wr_valid: ready is withdrawn so no word is taken.
  assign wr_ready      = (r_state == c_LOAD) && !abort;
  assign w_hs          = wr_ready && wr_valid;
  assign w_start_burst = (r_state == c_IDLE) && start && (word_count != '0);
  assign w_zero_start  = (r_state == c_IDLE) && start && (word_count == '0);
  assign w_last        = (r_count == CNT_WIDTH'(1));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_start_burst) w_state_nxt = c_REQ;
      end
      c_REQ: begin
        if (abort) begin
          w_state_nxt = c_FIN;
          w_err_nxt   = 1'b1;
        end else if (core_idle) begin
          w_state_nxt = c_ADDR;
        end
      end
      c_ADDR: begin
        if (abort) begin
          w_state_nxt = c_FIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = c_LOAD;
        end
      end
      c_LOAD: begin
        if (abort) begin
          w_state_nxt = c_FIN;
          w_err_nxt   = 1'b1;
        end else if (wr_valid) begin
          w_state_nxt = c_WRITE;
        end
      end
      c_WRITE: begin
        // The write in flight always completes; an abort here only matters
        // if words remain after it.
        if (w_last) begin
          w_state_nxt = c_FIN;
        end else if (abort) begin
          w_state_nxt = c_FIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = c_ADDR;
        end
      end
      c_FIN:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath register next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_words_nxt = r_words;
    if (w_start_burst) begin
      w_addr_nxt  = base_addr;
      w_count_nxt = word_count;
      w_words_nxt = '0;
    end
    if (w_hs) begin
      w_data_nxt = wr_data;
    end
    if (r_state == c_WRITE) begin
      w_addr_nxt  = r_addr + DATA_WIDTH'(1);
      w_count_nxt = r_count - CNT_WIDTH'(1);
      w_words_nxt = r_words + CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, so registered outputs line up with
  // the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hold_nxt     = 1'b0;
    w_ovr_en_nxt   = 1'b0;
    w_ovr_a_nxt    = 5'd0;
    w_ovr_we_nxt   = 1'b0;
    w_ovr_data_nxt = '0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = w_zero_start;
    w_err_out_nxt  = 1'b0;
    case (w_state_nxt)
      c_REQ: begin
        w_hold_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      c_ADDR: begin
        w_hold_nxt     = 1'b1;
        w_busy_nxt     = 1'b1;
        w_ovr_en_nxt   = 1'b1;
        w_ovr_a_nxt    = A_LDRAMD;
        w_ovr_data_nxt = w_addr_nxt;
      end
      c_LOAD: begin
        w_hold_nxt   = 1'b1;
        w_busy_nxt   = 1'b1;
        w_ovr_en_nxt = 1'b1;
      end
      c_WRITE: begin
        w_hold_nxt     = 1'b1;
        w_busy_nxt     = 1'b1;
        w_ovr_en_nxt   = 1'b1;
        w_ovr_a_nxt    = A_LDRAM;
        w_ovr_we_nxt   = 1'b1;
        w_ovr_data_nxt = w_data_nxt;
      end
      c_FIN: begin
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b1;
        w_err_out_nxt = w_err_nxt;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= c_IDLE;
      r_core_hold <= 1'b0;
      r_ovr_en    <= 1'b0;
      r_ovr_a     <= 5'd0;
      r_ovr_we    <= 1'b0;
      r_ovr_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_hold <= w_hold_nxt;
      r_ovr_en    <= w_ovr_en_nxt;
      r_ovr_a     <= w_ovr_a_nxt;
      r_ovr_we    <= w_ovr_we_nxt;
      r_ovr_data  <= w_ovr_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_out_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Address, count, data and progress registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_addr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_words <= '0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_words <= w_words_nxt;
    end
  end

  assign core_hold     = r_core_hold;
  assign ovr_en        = r_ovr_en;
  assign ovr_A         = r_ovr_a;
  assign ovr_WE        = r_ovr_we;
  assign ovr_data      = r_ovr_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_words;

endmodule
`default_nettype wire
